// File: rtl/store_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | store_unit: RV32I store lane alignment and single req/ack write port.  |
// | Optional STORE_SPLIT_EN splits misaligned stores into two beats.       |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        store_req_in,
  output logic        store_ready_out,
  input  logic [1:0]  store_size_in,
  input  logic [31:0] iadder_out_in,
  input  logic [31:0] rs2_in,
  output logic [31:0] dm_addr_out,
  output logic [31:0] dm_wdata_out,
  output logic [3:0]  dm_wr_mask_out,
  output logic        dm_wr_req_out,
  input  logic        dm_ack_in,
  output logic        store_done_out,
  output logic        misaligned_exc_out,
  output logic        bus_err_out
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off;
  logic [3:0]       base_mask;
  logic [31:0]      data_sized;
  logic [3:0]       lo_mask;
  logic [31:0]      lo_data;

  assign off             = iadder_out_in[1:0];
  assign store_ready_out = (state == IDLE);

  always_comb begin
    base_mask  = 4'b1111;
    data_sized = rs2_in;
    case (store_size_in)
      2'b00: begin
        base_mask  = 4'b0001;
        data_sized = {24'b0, rs2_in[7:0]};
      end
      2'b01: begin
        base_mask  = 4'b0011;
        data_sized = {16'b0, rs2_in[15:0]};
      end
      default: ;
    endcase
  end

`ifdef STORE_SPLIT_EN
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [3:0]  hi_mask_q;
  logic [31:0] hi_data_q;
  logic        split_pending;

  assign mask8              = {4'b0, base_mask} << off;
  assign data64             = {32'b0, data_sized} << {off, 3'b000};
  assign lo_mask            = mask8[3:0];
  assign lo_data            = data64[31:0];
  assign misaligned_exc_out = 1'b0;
`else
  logic misaligned;

  assign lo_mask    = base_mask << off;
  assign lo_data    = data_sized << {off, 3'b000};
  assign misaligned = ((store_size_in == 2'b01) && off[0]) ||
                      (store_size_in[1] && (off != 2'b00));
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      cnt            <= '0;
      dm_addr_out    <= '0;
      dm_wdata_out   <= '0;
      dm_wr_mask_out <= '0;
      dm_wr_req_out  <= 1'b0;
      store_done_out <= 1'b0;
      bus_err_out    <= 1'b0;
`ifdef STORE_SPLIT_EN
      hi_mask_q      <= '0;
      hi_data_q      <= '0;
      split_pending  <= 1'b0;
`else
      misaligned_exc_out <= 1'b0;
`endif
    end else begin
      store_done_out <= 1'b0;
      bus_err_out    <= 1'b0;
`ifndef STORE_SPLIT_EN
      misaligned_exc_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (store_req_in) begin
`ifdef STORE_SPLIT_EN
            state          <= WR1;
            cnt            <= '0;
            dm_addr_out    <= {iadder_out_in[31:2], 2'b00};
            dm_wdata_out   <= lo_data;
            dm_wr_mask_out <= lo_mask;
            dm_wr_req_out  <= 1'b1;
            hi_mask_q      <= mask8[7:4];
            hi_data_q      <= data64[63:32];
            split_pending  <= |mask8[7:4];
`else
            if (misaligned) begin
              misaligned_exc_out <= 1'b1;
            end else begin
              state          <= WR1;
              cnt            <= '0;
              dm_addr_out    <= {iadder_out_in[31:2], 2'b00};
              dm_wdata_out   <= lo_data;
              dm_wr_mask_out <= lo_mask;
              dm_wr_req_out  <= 1'b1;
            end
`endif
          end
        end
        WR1, WR2: begin
          // Ack takes priority over a timeout landing on the same cycle.
          if (dm_ack_in) begin
`ifdef STORE_SPLIT_EN
            if ((state == WR1) && split_pending) begin
              state          <= WR2;
              cnt            <= '0;
              dm_addr_out    <= dm_addr_out + 32'd4;
              dm_wdata_out   <= hi_data_q;
              dm_wr_mask_out <= hi_mask_q;
              split_pending  <= 1'b0;
            end else begin
              state          <= IDLE;
              dm_wr_req_out  <= 1'b0;
              dm_wdata_out   <= '0;
              dm_wr_mask_out <= '0;
              store_done_out <= 1'b1;
            end
`else
            state          <= IDLE;
            dm_wr_req_out  <= 1'b0;
            dm_wdata_out   <= '0;
            dm_wr_mask_out <= '0;
            store_done_out <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state          <= IDLE;
            dm_wr_req_out  <= 1'b0;
            dm_wdata_out   <= '0;
            dm_wr_mask_out <= '0;
            bus_err_out    <= 1'b1;
`ifdef STORE_SPLIT_EN
            split_pending  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
